// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the ID stage. A three-entry shadow pipeline
// tracks the destinations of in-flight writers in EXE, MEM and WB, and each
// entry is compared against the sources of the instruction currently in ID.
// The outputs are the stall and IF-flush controls and a saturating count of
// stalled cycles. Forwarding mode stalls only on load-use hazards.
// Non-forwarding mode stalls until the producer has left WB.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic        two_src,
  input  logic [4:0]  id_dest,
  input  logic        id_wb_en,
  input  logic        id_mem_r_en,
  input  logic        br_taken,
  input  logic        fwd_en,
  output logic        stall,
  output logic        if_flush,
  output logic        sb_busy,
  output logic [15:0] stall_cycles
);

  // Shadow entries: _p0 = EXE, _p1 = MEM, _p2 = WB.
  logic       vld_p0, vld_p1, vld_p2;
  logic [4:0] dest_p0, dest_p1, dest_p2;
  logic       load_p0;
  logic       load_p1, load_p2;

  logic       src1_used, src2_used;
  logic       hit_p0, hit_p1, hit_p2;
  logic       new_vld;

  // Register 0 is hard-wired, so an entry whose dest is r0 never matches.
  function automatic logic match_fn(input logic ev, input logic [4:0] ed,
                                    input logic u1, input logic [4:0] r1,
                                    input logic u2, input logic [4:0] r2);
    return ev && (ed != 5'd0) && ((u1 && (r1 == ed)) || (u2 && (r2 == ed)));
  endfunction

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] cur);
    return (cur == 16'hFFFF) ? cur : cur + 16'd1;
  endfunction

  // Combinational hazard detection and the derived stall, flush and busy outputs.
  always_comb begin
    src1_used = id_valid;
    src2_used = id_valid & two_src;
    hit_p0    = match_fn(vld_p0, dest_p0, src1_used, src1, src2_used, src2);
    hit_p1    = match_fn(vld_p1, dest_p1, src1_used, src1, src2_used, src2);
    hit_p2    = match_fn(vld_p2, dest_p2, src1_used, src1, src2_used, src2);
    // A WB writer is still a hazard without forwarding: the register file
    // writes on the same edge on which ID would otherwise consume the value.
    if (fwd_en) stall = hit_p0 & load_p0;
    else        stall = hit_p0 | hit_p1 | hit_p2;
    // A branch that is held waiting for its operands flushes only when it issues.
    if_flush  = br_taken & ~stall;
    sb_busy   = vld_p0 | vld_p1 | vld_p2;
    // A stalled instruction enters EXE as a bubble. Writes to r0 are never tracked.
    new_vld   = id_valid & ~stall & id_wb_en & (id_dest != 5'd0);
  end

  // Control state: entry valid bits and the stall counter, cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      // ID -> EXE
      vld_p0 <= new_vld;
      // EXE -> MEM
      vld_p1 <= vld_p0;
      // MEM -> WB
      vld_p2 <= vld_p1;
      if (stall) stall_cycles <= sat_inc(stall_cycles);
    end
  end

  // Data fields advance every cycle. They are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    // ID -> EXE
    dest_p0 <= id_dest;
    load_p0 <= id_mem_r_en;
    // EXE -> MEM
    dest_p1 <= dest_p0;
    load_p1 <= load_p0;
    // MEM -> WB
    dest_p2 <= dest_p1;
    load_p2 <= load_p1;
  end

  // The load flags of MEM and WB travel with their entries for completeness.
  // Only the EXE flag feeds the load-use check.
  logic unused_load;
  assign unused_load = load_p1 ^ load_p2;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Each step drives the ID-stage inputs
// and pushes the expected outputs for that cycle onto a queue. The queue is
// popped and compared at the following falling edge.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic        two_src;
  logic [4:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_r_en;
  logic        br_taken;
  logic        fwd_en;
  logic        stall;
  logic        if_flush;
  logic        sb_busy;
  logic [15:0] stall_cycles;

  typedef struct {
    string       tag;
    logic        st;
    logic        fl;
    logic        bz;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_assert;
  int   n_fail;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .src1         (src1),
    .src2         (src2),
    .two_src      (two_src),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .br_taken     (br_taken),
    .fwd_en       (fwd_en),
    .stall        (stall),
    .if_flush     (if_flush),
    .sb_busy      (sb_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic two, input logic [4:0] dst, input logic wb,
                        input logic ld, input logic br);
    id_valid    = v;
    src1        = s1;
    src2        = s2;
    two_src     = two;
    id_dest     = dst;
    id_wb_en    = wb;
    id_mem_r_en = ld;
    br_taken    = br;
  endtask

  task automatic set_idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_o(input string tag, input logic st, input logic fl,
                          input logic bz, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.st = st; e.fl = fl; e.bz = bz; e.cnt = cnt;
    q.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then
  // advance to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_assert++;
      assert (stall === e.st) else begin
        n_fail++;
        $error("FAIL %s stall: got %0b expected %0b", e.tag, stall, e.st);
      end
      n_assert++;
      assert (if_flush === e.fl) else begin
        n_fail++;
        $error("FAIL %s if_flush: got %0b expected %0b", e.tag, if_flush, e.fl);
      end
      n_assert++;
      assert (sb_busy === e.bz) else begin
        n_fail++;
        $error("FAIL %s sb_busy: got %0b expected %0b", e.tag, sb_busy, e.bz);
      end
      n_assert++;
      assert (stall_cycles === e.cnt) else begin
        n_fail++;
        $error("FAIL %s stall_cycles: got %h expected %h", e.tag, stall_cycles, e.cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    fwd_en   = 1'b0;
    // The first reset edge is taken with a live writer and a taken branch in ID.
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    expect_o("rst_flush_hi", 1'b0, 1'b1, 1'b0, 16'd0);
    tick();
    br_taken = 1'b0;
    expect_o("rst_flush_lo", 1'b0, 1'b0, 1'b0, 16'd0);
    tick();
    rst = 1'b0;
    set_idle();
    tick();

    // No-forward RAW: ADD r3<-r1,r2 then SUB r4<-r3,r5
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    expect_o("raw_prod", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_o("raw_st_exe", 1'b1, 1'b0, 1'b1, 16'd0); tick();
    expect_o("raw_st_mem", 1'b1, 1'b0, 1'b1, 16'd1); tick();
    expect_o("raw_st_wb",  1'b1, 1'b0, 1'b1, 16'd2); tick();
    expect_o("raw_issue",  1'b0, 1'b0, 1'b0, 16'd3); tick();
    set_idle();
    expect_o("raw_cons_exe", 1'b0, 1'b0, 1'b1, 16'd3); tick();

    // Load-use with forwarding: LD r7 then ADD r8<-r7,r9
    do_reset();
    fwd_en = 1'b1;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    expect_o("lu_load", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd7, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_o("lu_stall", 1'b1, 1'b0, 1'b1, 16'd0); tick();
    expect_o("lu_issue", 1'b0, 1'b0, 1'b1, 16'd1); tick();
    set_idle();
    expect_o("lu_after", 1'b0, 1'b0, 1'b1, 16'd1); tick();

    // Forwarding, non-load producer: no stall
    do_reset();
    fwd_en = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    expect_o("nf_prod", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_o("nf_cons", 1'b0, 1'b0, 1'b1, 16'd0); tick();

    // fwd_en switched on in mid-stall releases the consumer in the same cycle
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    expect_o("flip_prod", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_o("flip_st", 1'b1, 1'b0, 1'b1, 16'd0); tick();
    fwd_en = 1'b1;
    expect_o("flip_go", 1'b0, 1'b0, 1'b1, 16'd1); tick();

    // Writer to r0 followed by a reader of r0, in both modes
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    expect_o("r0_wr", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    expect_o("r0_rd_nofwd", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    fwd_en = 1'b1;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    expect_o("r0_ld", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    expect_o("r0_rd_fwd", 1'b0, 1'b0, 1'b0, 16'd0); tick();

    // src2 matches EXE, but two_src=0 means src2 is not read
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    expect_o("t2_prod", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd1, 5'd6, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    expect_o("t2_cons", 1'b0, 1'b0, 1'b1, 16'd0); tick();

    // Distance 2 without forwarding: two stall cycles
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    expect_o("d2_prod", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_o("d2_mid", 1'b0, 1'b0, 1'b1, 16'd0); tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_o("d2_st1", 1'b1, 1'b0, 1'b1, 16'd0); tick();
    expect_o("d2_st2", 1'b1, 1'b0, 1'b1, 16'd1); tick();
    expect_o("d2_issue", 1'b0, 1'b0, 1'b1, 16'd2); tick();

    // Both sources hit different stages: held until the younger one leaves WB
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    expect_o("bs_p1", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_o("bs_p2", 1'b0, 1'b0, 1'b1, 16'd0); tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_o("bs_st1", 1'b1, 1'b0, 1'b1, 16'd0); tick();
    expect_o("bs_st2", 1'b1, 1'b0, 1'b1, 16'd1); tick();
    expect_o("bs_st3", 1'b1, 1'b0, 1'b1, 16'd2); tick();
    expect_o("bs_issue", 1'b0, 1'b0, 1'b0, 16'd3); tick();

    // Dependent taken branch: the flush waits for the issue cycle
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    expect_o("br_prod", 1'b0, 1'b0, 1'b0, 16'd0); tick();
    set_id(1'b1, 5'd2, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_o("br_st1", 1'b1, 1'b0, 1'b1, 16'd0); tick();
    expect_o("br_st2", 1'b1, 1'b0, 1'b1, 16'd1); tick();
    expect_o("br_st3", 1'b1, 1'b0, 1'b1, 16'd2); tick();
    expect_o("br_issue", 1'b0, 1'b1, 1'b0, 16'd3); tick();
    set_idle();
    expect_o("br_after", 1'b0, 1'b0, 1'b0, 16'd3); tick();

    // Saturation: ADD r3<-r3 held in ID stalls 3 of every 4 cycles
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    repeat (4 * 21844) @(posedge clk);
    #1;
    expect_o("sat_fffc", 1'b0, 1'b0, 1'b0, 16'hFFFC); tick();
    expect_o("sat_c1", 1'b1, 1'b0, 1'b1, 16'hFFFC); tick();
    expect_o("sat_c2", 1'b1, 1'b0, 1'b1, 16'hFFFD); tick();
    expect_o("sat_c3", 1'b1, 1'b0, 1'b1, 16'hFFFE); tick();
    expect_o("sat_full", 1'b0, 1'b0, 1'b0, 16'hFFFF); tick();
    expect_o("sat_hold1", 1'b1, 1'b0, 1'b1, 16'hFFFF); tick();
    // Assert rst in the middle of a stall
    rst = 1'b1;
    expect_o("sat_hold2", 1'b1, 1'b0, 1'b1, 16'hFFFF); tick();
    rst = 1'b0;
    expect_o("rst_midstall", 1'b0, 1'b0, 1'b0, 16'd0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
